delayn: RTL and testbench

Parametrised, runtime-selectable sample delay line for the DSP filter chain. It delays a strobed sample stream by 0..MAX_DLY samples through a circular buffer, and outputs zero until enough history exists. It replaces the fixed single-register 8-bit `delayw` as the building block for FIR tap lines, comb filters and board-level LED demos. It sits between a sample source (ADC/test generator with a sample strobe) and downstream filter arithmetic.

---
 rtl/delayn_pkg.sv | 15 +
 rtl/delayn_ram.sv | 30 +++
 rtl/delayn.sv | 78 +++++++
 tb/tb_delayn.sv | 133 +++++++++++++
 4 files changed

// File: rtl/delayn_pkg.sv
// Shared DSP constants and helpers for the delay line and FIR tap lines.
package delayn_pkg;

  localparam int DW_DEF      = 8;
  localparam int MAX_DLY_DEF = 16;

  // Smallest r with 2**r >= v; usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/delayn_ram.sv
// Single-clock DEPTH x DW memory: one write port, one asynchronous read port, no reset.
module delayn_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 6
)(
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // Address decode by compare so the address may be wider than the depth needs.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (i_we && (i_waddr == AW'(i))) r_mem[i] <= i_wdata;
  end

  // Async read sees the pre-edge contents, giving read-before-write.
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < DEPTH; i++)
      if (i_raddr == AW'(i)) o_rdata = r_mem[i];
  end

endmodule

// File: rtl/delayn.sv
// Runtime-selectable 0..MAX_DLY sample delay line over a circular buffer,
// outputting zero until enough history has been written.
module delayn
  import delayn_pkg::*;
#(
  parameter  int DW      = DW_DEF,
  parameter  int MAX_DLY = MAX_DLY_DEF,
  localparam int LW      = clog2(MAX_DLY + 1)
)(
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic [DW-1:0] i_data,
  input  logic [LW-1:0] i_delay,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  output logic          o_primed
);

  localparam int            PW    = LW + 1;
  localparam logic [LW-1:0] MAXD  = LW'(MAX_DLY);
  localparam logic [LW-1:0] LASTW = LW'(MAX_DLY - 1);

  logic [LW-1:0] r_wp;
  logic [LW-1:0] r_fill;
  logic [DW-1:0] r_data;
  logic          r_valid;

  logic [LW-1:0] w_de;
  logic [PW-1:0] w_wp_x;
  logic [PW-1:0] w_de_x;
  logic [PW-1:0] w_ra;
  logic [DW-1:0] w_rdata;

  assign w_de   = (i_delay > MAXD) ? MAXD : i_delay;
  assign w_wp_x = {1'b0, r_wp};
  assign w_de_x = {1'b0, w_de};
  // Explicit modular wrap; MAX_DLY need not be a power of two.
  assign w_ra   = (w_wp_x >= w_de_x) ? (w_wp_x - w_de_x)
                                     : (w_wp_x + PW'(MAX_DLY) - w_de_x);

  delayn_ram #(
    .DW    (DW),
    .DEPTH (MAX_DLY),
    .AW    (PW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (i_ce),
    .i_waddr (w_wp_x),
    .i_wdata (i_data),
    .i_raddr (w_ra),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wp    <= '0;
      r_fill  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_ce;
      if (i_ce) begin
        // Stale buffer contents are masked until fill covers the delay.
        if (w_de == '0)          r_data <= i_data;
        else if (r_fill < w_de)  r_data <= '0;
        else                     r_data <= w_rdata;
        r_wp   <= (r_wp == LASTW) ? '0 : r_wp + 1'b1;
        r_fill <= (r_fill == MAXD) ? r_fill : r_fill + 1'b1;
      end
    end
  end

  assign o_data   = r_data;
  assign o_valid  = r_valid;
  assign o_primed = (r_fill >= w_de);

endmodule

// File: tb/tb_delayn.sv
// Directed self-checking bench for delayn (DW=8, MAX_DLY=16).
module tb_delayn;

  localparam int DW = 8;
  localparam int MD = 16;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce;
  logic [DW-1:0] din;
  logic [LW-1:0] dly;
  logic [DW-1:0] dout;
  logic          vld;
  logic          primed;

  int n_cmp = 0;
  int n_err = 0;

  delayn #(.DW(DW), .MAX_DLY(MD)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_ce      (ce),
    .i_data    (din),
    .i_delay   (dly),
    .o_data    (dout),
    .o_valid   (vld),
    .o_primed  (primed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int d);
    ce = 1'b0; din = '0; dly = LW'(d);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_data_async", int'(dout), 0);
    chk("rst_valid_async", int'(vld), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One strobe; checks the registered result one cycle later.
  task automatic strobe(input string tag, input int x, input int d, input int exp);
    ce = 1'b1; din = DW'(x); dly = LW'(d);
    @(posedge clk); #1;
    chk(tag, int'(dout), exp);
    chk({tag, "_valid"}, int'(vld), 1);
    ce = 1'b0;
  endtask

  task automatic idle(input string tag, input int exp);
    ce = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_hold"}, int'(dout), exp);
    chk({tag, "_valid"}, int'(vld), 0);
  endtask

  function automatic int ramp_exp(input int k, input int de, input int base);
    return (k < de) ? 0 : base + k - de;
  endfunction

  initial begin
    rst_n = 1'b1; ce = 1'b0; din = '0; dly = 5'd3;

    // Reset state
    do_reset(3);
    chk("reset_primed_d3", int'(primed), 0);

    // Ramp with D=3: 0,0,0,1,2,...; primed after 3rd strobe
    for (int k = 0; k < 10; k++) begin
      strobe("ramp_d3", k + 1, 3, ramp_exp(k, 3, 1));
      chk("ramp_d3_primed", int'(primed), (k >= 2) ? 1 : 0);
    end

    // Zero delay
    do_reset(0);
    chk("d0_primed_reset", int'(primed), 1);
    strobe("d0_a5", 8'hA5, 0, 8'hA5);
    strobe("d0_5a", 8'h5A, 0, 8'h5A);

    // Maximum delay and clamp give identical streams
    do_reset(16);
    for (int k = 0; k < 20; k++) begin
      strobe("max_d16", k + 1, 16, ramp_exp(k, 16, 1));
      chk("max_d16_primed", int'(primed), (k >= 15) ? 1 : 0);
    end
    do_reset(31);
    chk("clamp_primed_reset", int'(primed), 0);
    for (int k = 0; k < 20; k++) begin
      strobe("clamp_d31", k + 1, 31, ramp_exp(k, 16, 1));
      chk("clamp_d31_primed", int'(primed), (k >= 15) ? 1 : 0);
    end

    // Gapped strobes, D=2
    do_reset(2);
    for (int k = 0; k < 8; k++) begin
      strobe("gap_d2", 10 + k, 2, ramp_exp(k, 2, 10));
      idle("gap_d2_i1", ramp_exp(k, 2, 10));
      idle("gap_d2_i2", ramp_exp(k, 2, 10));
    end

    // Mid-stream delay change
    do_reset(2);
    for (int k = 0; k < 20; k++) strobe("mid_d2", k + 1, 2, ramp_exp(k, 2, 1));
    strobe("mid_d5_a", 21, 5, 16);
    strobe("mid_d5_b", 22, 5, 17);
    strobe("mid_d1_a", 23, 1, 22);
    strobe("mid_d1_b", 24, 1, 23);

    // Reset after 10 samples, then D=4: no stale data leaks
    do_reset(4);
    for (int k = 0; k < 10; k++) strobe("pre_rst", 100 + k, 4, ramp_exp(k, 4, 100));
    do_reset(4);
    chk("post_rst_primed", int'(primed), 0);
    for (int k = 0; k < 8; k++) begin
      strobe("post_rst_d4", 200 + k, 4, ramp_exp(k, 4, 200));
      chk("post_rst_primed_k", int'(primed), (k >= 3) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
